product_bcd_converter: RTL and testbench

Downstream stage of the 4x4 shift-add multiplier. Captures the 8-bit product when the multiplier's Halt rises, then converts it to three packed BCD digits with a sequential double-dabble, one shift per clock. The result feeds the seven-segment display driver. A Done pulse marks each new result.

---
 rtl/mult_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 13 +
 rtl/product_bcd_converter.sv | 107 ++++++++++
 tb/tb_product_bcd_converter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier and its BCD back end.
// Holds the converter state encoding and the default product / digit sizes.
// Ports: none (package only).
package mult_pkg;

  localparam int PRODUCT_W  = 8;
  localparam int BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to any BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
// Latency: combinational. Backpressure: none.
// Ports: digit_in (4-bit BCD digit before shift), digit_out (corrected digit).
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // digit_in is at most 9, so digit_in + 3 fits in 4 bits with no carry out.
  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule : bcd_digit_adjust

// File: rtl/product_bcd_converter.sv
// Captures the multiplier product on a rising Trigger edge and converts it to
// packed BCD with a sequential double-dabble, one shift per clock.
// Latency: WIDTH clocks from the accepting edge to Bcd/Done; new requests are
// dropped while SHIFT or DONE is active (no queueing).
// Ports: Clock, Reset (async active-low), Trigger (level, rising edge starts),
// Product (binary in), Bcd (packed BCD out), Busy (in SHIFT), Done (1-cycle pulse).
module product_bcd_converter
  import mult_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Trigger,
  input  logic [WIDTH-1:0]      Product,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Busy,
  output logic                  Done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               trig_q;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               req;
  logic [BCD_W-1:0]   adj_digits;
  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_shift;

  // Upper BCD_W bits of the shift register hold the decimal digits being built.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (sr_q[WIDTH + 4*g +: 4]),
      .digit_out (adj_digits[4*g +: 4])
    );
  end

  assign sr_adj   = {adj_digits, sr_q[WIDTH-1:0]};
  assign sr_shift = sr_adj << 1;

  // trig_q resets to 1 so a Trigger already high at reset release is not an edge.
  assign req = Trigger & ~trig_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          sr_d    = {{BCD_W{1'b0}}, Product};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_d   = sr_shift[SR_W-1 -: BCD_W];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they align with state_q.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      trig_q  <= 1'b1;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= Trigger;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Bcd  = bcd_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule : product_bcd_converter

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed scenarios plus random
// products compared against a decimal-arithmetic reference model.
// Ports: none (top-level bench).
module tb_product_bcd_converter;

  logic        Clock;
  logic        Reset;
  logic        Trigger;
  logic [7:0]  Product;
  logic [11:0] Bcd;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] last_bcd = 12'h000;  // model of the value Bcd should be holding

  product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Trigger (Trigger),
    .Product (Product),
    .Bcd     (Bcd),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: decimal digits of v computed with plain arithmetic.
  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Start a conversion of p and observe it for up to max_i negedges after the
  // accepting edge. Mode 0: drop Trigger after acceptance. Mode 1: hold
  // Trigger high. Mode 2: pulse a second edge with Product=200 mid-conversion.
  task automatic convert(input int p, input int mode, input int max_i, input string tag);
    int busy_cnt, done_cnt, done_at, early;
    logic [11:0] exp_bcd;
    exp_bcd  = to_bcd(p);
    busy_cnt = 0; done_cnt = 0; done_at = -1; early = 0;
    @(negedge Clock);
    Product = 8'(p);
    Trigger = 1'b1;
    for (int i = 1; i <= max_i; i++) begin
      @(negedge Clock);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i < 9 && Bcd !== last_bcd) early++;
      if (mode == 0 && i == 1) Trigger = 1'b0;
      if (mode == 2) begin
        if (i == 3) Trigger = 1'b0;
        if (i == 5) begin Trigger = 1'b1; Product = 8'd200; end
        if (i == 7) Trigger = 1'b0;
      end
      if (mode == 0 && i == 2) Product = 8'($urandom_range(0, 255));
    end
    check({tag, " busy_cycles"}, busy_cnt, 8);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_latency"}, done_at, 9);
    check({tag, " bcd_early_change"}, early, 0);
    check({tag, " bcd"}, Bcd, exp_bcd);
    last_bcd = exp_bcd;
  endtask

  initial begin
    int busy_seen, done_seen;
    Reset   = 1'b0;
    Trigger = 1'b0;
    Product = 8'd0;
    repeat (3) @(negedge Clock);
    check("in_reset_bcd", Bcd, 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    check("reset_bcd", Bcd, 0);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);

    convert(225, 0, 20, "first_225");

    begin
      int sweep[6] = '{0, 9, 10, 99, 100, 255};
      foreach (sweep[k]) convert(sweep[k], 0, 20, $sformatf("sweep_%0d", sweep[k]));
    end

    // Trigger held high: exactly one conversion.
    convert(144, 1, 30, "hold_144");
    @(negedge Clock) Trigger = 1'b0;

    // Mid-conversion edge is dropped; next real edge converts 200.
    convert(37, 2, 20, "glitch_37");
    convert(200, 0, 20, "after_glitch_200");

    // Back-to-back: new edge in the cycle right after Done.
    convert(50, 0, 9, "b2b_first_50");
    convert(81, 0, 20, "b2b_81");

    // Random products against the reference model.
    for (int r = 0; r < 12; r++) convert($urandom_range(0, 255), 0, 20, $sformatf("rand_%0d", r));

    // Reset during the 4th SHIFT cycle aborts the conversion.
    @(negedge Clock);
    Product = 8'd225;
    Trigger = 1'b1;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_bcd", Bcd, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;  // released with Trigger still high
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      if (Busy) busy_seen++;
      if (Done) done_seen++;
    end
    check("post_abort_busy", busy_seen, 0);
    check("post_abort_done", done_seen, 0);
    check("post_abort_bcd", Bcd, 0);
    last_bcd = 12'h000;
    Trigger = 1'b0;
    convert(123, 0, 20, "recover_123");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_product_bcd_converter
